// File: rtl/mac_nch_sat.sv
// mac_nch_sat: multi-channel interleaved multiply-accumulate with symmetric
// rounding and symmetric saturation. Four fixed stages: input register,
// full-precision product, per-channel accumulate, round/saturate/output.
module mac_nch_sat #(
  parameter int DW      = 18,
  parameter int CW      = 25,
  parameter int OW      = 20,
  parameter int GUARD   = 2,
  parameter int OUT_MSB = DW + CW - 2,
  parameter int NCH     = 4,
  parameter int RND     = 1,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld,
  input  logic signed [DW-1:0] din,
  input  logic signed [CW-1:0] cin,
  input  logic [CHW-1:0]       ch,
  input  logic                 first,
  input  logic                 last,
  output logic [OW-1:0]        dout,
  output logic [CHW-1:0]       dch,
  output logic                 ov,
  output logic                 ovf,
  output logic                 ovf_any
);

  localparam int PW   = DW + CW;
  localparam int ACCW = PW + GUARD;
  localparam int LSB  = OUT_MSB - OW + 1;

  // Half an output LSB, expressed at the widened accumulator precision.
  localparam logic [ACCW:0] RC_HALF = (LSB > 0) ? ((ACCW + 1)'(1) << ((LSB > 0) ? LSB - 1 : 0)) : '0;
  // Negative sums add one less so exact halves round away from zero.
  localparam logic [ACCW:0] RC_POS  = (RND != 0) ? RC_HALF : '0;
  localparam logic [ACCW:0] RC_NEG  = (RND != 0 && LSB > 0) ? RC_HALF - 1'b1 : '0;

  localparam logic [OW-1:0] SAT_POS = {1'b0, {(OW - 1){1'b1}}};
  localparam logic [OW-1:0] SAT_NEG = {1'b1, {(OW - 2){1'b0}}, 1'b1};

  // Stage 1 registers
  logic                 r1_vld, r1_first, r1_last;
  logic signed [DW-1:0] r1_din;
  logic signed [CW-1:0] r1_cin;
  logic [CHW-1:0]       r1_ch;
  // Stage 2 registers
  logic                 r2_vld, r2_first, r2_last;
  logic signed [PW-1:0] r2_prod;
  logic [CHW-1:0]       r2_ch;
  // Stage 3 registers and accumulators
  logic                   r3_vld;
  logic signed [ACCW-1:0] r3_sum;
  logic [CHW-1:0]         r3_ch;
  logic signed [ACCW-1:0] r_acc [NCH];

  logic                   w_ch_ok;
  logic signed [PW-1:0]   w_din_ext, w_cin_ext;
  logic signed [ACCW-1:0] w_prod_ext, w_acc_cur, w_acc_next;
  logic                   w_neg, w_ovf;
  logic [ACCW:0]          w_sum_ext, w_rnd;
  logic [OW-1:0]          w_dout;

  // Terms addressed to a channel that does not exist are dropped at entry.
  assign w_ch_ok = ({1'b0, ch} < (CHW + 1)'(NCH));

  // S1: capture the incoming term.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_vld   <= 1'b0;
      r1_first <= 1'b0;
      r1_last  <= 1'b0;
      r1_din   <= '0;
      r1_cin   <= '0;
      r1_ch    <= '0;
    end else begin
      r1_vld   <= vld && w_ch_ok;
      r1_first <= first;
      r1_last  <= last;
      r1_din   <= din;
      r1_cin   <= cin;
      r1_ch    <= ch;
    end
  end

  assign w_din_ext = {{CW{r1_din[DW-1]}}, r1_din};
  assign w_cin_ext = {{DW{r1_cin[CW-1]}}, r1_cin};

  // S2: full-precision signed product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_vld   <= 1'b0;
      r2_first <= 1'b0;
      r2_last  <= 1'b0;
      r2_prod  <= '0;
      r2_ch    <= '0;
    end else begin
      r2_vld   <= r1_vld;
      r2_first <= r1_first;
      r2_last  <= r1_last;
      r2_prod  <= w_din_ext * w_cin_ext;
      r2_ch    <= r1_ch;
    end
  end

  assign w_prod_ext = ACCW'(r2_prod);

  // Select the running sum of the channel this term belongs to.
  always_comb begin
    w_acc_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r2_ch == CHW'(i)) w_acc_cur = r_acc[i];
    end
  end

  // A first term restarts the sum, discarding any unfinished partial.
  assign w_acc_next = r2_first ? w_prod_ext : w_acc_cur + w_prod_ext;

  // S3: per-channel accumulate; a last term forwards its total to S4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      r3_vld <= 1'b0;
      r3_sum <= '0;
      r3_ch  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r2_vld && r2_ch == CHW'(i)) r_acc[i] <= w_acc_next;
      end
      r3_vld <= r2_vld && r2_last;
      r3_sum <= w_acc_next;
      r3_ch  <= r2_ch;
    end
  end

  // Round with one extra headroom bit so the rounding add itself cannot wrap.
  assign w_neg     = r3_sum[ACCW-1];
  assign w_sum_ext = {w_neg, r3_sum};
  assign w_rnd     = w_sum_ext + (w_neg ? RC_NEG : RC_POS);
  assign w_ovf     = !((&w_rnd[ACCW:OUT_MSB]) || !(|w_rnd[ACCW:OUT_MSB]));
  assign w_dout    = w_ovf ? (w_neg ? SAT_NEG : SAT_POS) : w_rnd[OUT_MSB:LSB];

  // S4: register the result; dout/dch/ovf hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov      <= 1'b0;
      dout    <= '0;
      dch     <= '0;
      ovf     <= 1'b0;
      ovf_any <= 1'b0;
    end else begin
      ov <= r3_vld;
      if (r3_vld) begin
        dout <= w_dout;
        dch  <= r3_ch;
        ovf  <= w_ovf;
      end
      ovf_any <= ovf_any | (r3_vld & w_ovf);
    end
  end

endmodule

// File: tb/tb_mac_nch_sat.sv
// tb_mac_nch_sat: directed vectors with hand-computed results, driven into
// two builds at once: a = defaults (NCH=4, rounding), b = NCH=3, truncation.
// Expected results are queued at issue time; a monitor pops on every ov.
module tb_mac_nch_sat;

  localparam int P22 = 1 << 22;
  localparam int P21 = 1 << 21;

  logic        clk = 1'b0;
  logic        rst, vld, first, last;
  logic [17:0] din;
  logic [24:0] cin;
  logic [1:0]  ch;

  logic [19:0] dout_a, dout_b;
  logic [1:0]  dch_a, dch_b;
  logic        ov_a, ov_b, ovf_a, ovf_b, any_a, any_b;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [19:0] dout;
    logic [1:0]  dch;
    logic        ovf;
    logic        any;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_nch_sat u_a (
    .clk(clk), .rst(rst), .vld(vld), .din(din), .cin(cin), .ch(ch),
    .first(first), .last(last), .dout(dout_a), .dch(dch_a), .ov(ov_a),
    .ovf(ovf_a), .ovf_any(any_a)
  );

  mac_nch_sat #(.NCH(3), .RND(0)) u_b (
    .clk(clk), .rst(rst), .vld(vld), .din(din), .cin(cin), .ch(ch),
    .first(first), .last(last), .dout(dout_b), .dch(dch_b), .ov(ov_b),
    .ovf(ovf_b), .ovf_any(any_b)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void cmp_out(string tag, exp_t e, logic [19:0] d, logic [1:0] c,
                                  logic f, logic a);
    chk({tag, "_dout"}, 32'(d), 32'(e.dout));
    chk({tag, "_dch"}, 32'(c), 32'(e.dch));
    chk({tag, "_ovf"}, 32'(f), 32'(e.ovf));
    chk({tag, "_ovf_any"}, 32'(a), 32'(e.any));
    chk({tag, "_latency"}, 32'(cyc - e.cyc), 32'd4);
    $display("%s: cyc=%0d dch=%0d dout=0x%05h ovf=%0b ovf_any=%0b", tag, cyc, c, d, f, a);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ov_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ov: got strobe dch=%0d dout=0x%05h, required none", dch_a, dout_a);
      end else cmp_out("a", q_a.pop_front(), dout_a, dch_a, ovf_a, any_a);
    end
    if (ov_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ov: got strobe dch=%0d dout=0x%05h, required none", dch_b, dout_b);
      end else cmp_out("b", q_b.pop_front(), dout_b, dch_b, ovf_b, any_b);
    end
  end

  task automatic term(input int c, input int d, input int k, input bit f, input bit l);
    @(posedge clk); #1;
    vld = 1'b1; ch = 2'(c); din = 18'(d); cin = 25'(k); first = f; last = l;
  endtask

  // Bubbles carry junk with first/last set; they must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vld = 1'b0; ch = 2'd0; din = '1; cin = '1; first = 1'b1; last = 1'b1;
    end
  endtask

  task automatic exp_a(input int d, input int c, input bit f, input bit a);
    q_a.push_back('{dout: 20'(d), dch: 2'(c), ovf: f, any: a, cyc: cyc});
  endtask

  task automatic exp_b(input int d, input int c, input bit f, input bit a);
    q_b.push_back('{dout: 20'(d), dch: 2'(c), ovf: f, any: a, cyc: cyc});
  endtask

  task automatic exp_both(input int d, input int c, input bit f, input bit a);
    exp_a(d, c, f, a);
    exp_b(d, c, f, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; vld = 1'b0; ch = '0; din = '0; cin = '0; first = 1'b0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_dout", 32'(dout_a), 0);
    chk("rst_a_dch", 32'(dch_a), 0);
    chk("rst_a_ov", 32'(ov_a), 0);
    chk("rst_a_ovf", 32'(ovf_a), 0);
    chk("rst_a_ovf_any", 32'(any_a), 0);
    chk("rst_b_dout", 32'(dout_b), 0);
    chk("rst_b_ov", 32'(ov_b), 0);
    chk("rst_b_ovf_any", 32'(any_b), 0);
    rst = 1'b1;
    idle(2);

    // Single-term sums: unit value and rounding around half an LSB.
    term(0, 1, P22, 1, 1);   exp_both(1, 0, 0, 0);
    term(0, 3, P21, 1, 1);   exp_a(2, 0, 0, 0);  exp_b(1, 0, 0, 0);
    term(0, -3, P21, 1, 1);  exp_both(-2, 0, 0, 0);
    term(0, 1, P21, 1, 1);   exp_a(1, 0, 0, 0);  exp_b(0, 0, 0, 0);
    term(0, -1, P21, 1, 1);  exp_both(-1, 0, 0, 0);
    idle(2);

    // Positive overflow, an in-range near-full-scale negative, negative overflow.
    term(1, 131071, 16777215, 1, 0);
    term(1, 131071, 16777215, 0, 1);   exp_both(20'h7FFFF, 1, 1, 1);
    term(1, -131071, 16777215, 1, 1);  exp_both(20'h80004, 1, 0, 1);
    term(1, -131071, 16777215, 1, 0);
    term(1, -131071, 16777215, 0, 1);  exp_both(20'h80001, 1, 1, 1);
    idle(2);

    // Channels 0 and 1 interleaved every cycle.
    for (int i = 0; i < 8; i++) begin
      term(i % 2, (i % 2 == 1) ? 2 : 1, P22, i < 2, i >= 6);
      if (i >= 6) exp_both((i % 2 == 1) ? 8 : 4, i % 2, 0, 1);
    end
    // Same channel on consecutive cycles.
    term(2, 1, P22, 1, 0);
    term(2, 1, P22, 0, 0);
    term(2, 1, P22, 0, 1);   exp_both(3, 2, 0, 1);
    // A second first abandons the earlier partial sum.
    term(2, 5, P22, 1, 0);
    term(2, 1, P22, 1, 0);
    term(2, 2, P22, 0, 1);   exp_both(3, 2, 0, 1);
    // Channel 3 is real in build a and nonexistent in build b; a bubble mid-sum.
    term(0, 1, P22, 1, 0);
    term(3, 7, P22, 1, 1);   exp_a(7, 3, 0, 1);
    term(0, 1, P22, 0, 0);
    idle(1);
    term(0, 1, P22, 0, 1);   exp_both(3, 0, 0, 1);
    idle(3);

    // Reset pulse in the middle of a five-term sum.
    term(0, 1, P22, 1, 0);
    term(0, 1, P22, 0, 0);
    term(0, 1, P22, 0, 0);
    @(posedge clk); #1;
    vld = 1'b0; rst = 1'b0;
    #1;
    chk("midrst_a_ovf_any", 32'(any_a), 0);
    chk("midrst_b_ovf_any", 32'(any_b), 0);
    chk("midrst_a_dout", 32'(dout_a), 0);
    chk("midrst_a_ov", 32'(ov_a), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(6);
    term(0, 2, P22, 0, 1);   exp_both(2, 0, 0, 0);
    term(0, 1, P22, 1, 1);   exp_both(1, 0, 0, 0);
    idle(8);

    chk("a_queue_drained", 32'(q_a.size()), 0);
    chk("b_queue_drained", 32'(q_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_nch_sat.md
MAC_NCH_SAT -- requirements
Module: mac_nch_sat

Interface
REQ-001 SHALL have parameter DW, default 18, signed data width.
REQ-002 SHALL have parameter CW, default 25, signed coefficient width.
REQ-003 SHALL have parameter OW, default 20, output width.
REQ-004 SHALL have parameter GUARD, default 2, accumulator guard bits; PW=DW+CW, ACCW=PW+GUARD.
REQ-005 SHALL have parameter OUT_MSB, default PW-2 (41), accumulator bit mapped to the dout sign bit.
REQ-006 SHALL have parameter NCH, default 4, number of interleaved channels; CHW=max(1,clog2(NCH)).
REQ-007 SHALL have parameter RND, default 1, where 0 is truncate and 1 is symmetric round-half-away-from-zero.
REQ-008 clk  input  1  single master clock; all logic on rising edge.
REQ-009 rst  input  1  reset, asynchronous and active-low.
REQ-010 vld  input  1  din/cin/ch/first/last valid this cycle.
REQ-011 din  input  DW  signed data.
REQ-012 cin  input  CW  signed coefficient.
REQ-013 ch  input  CHW  channel index of this term.
REQ-014 first  input  1  first term of a sum for channel ch.
REQ-015 last  input  1  last term of a sum for channel ch.
REQ-016 dout  output  OW  rounded, saturated sum.
REQ-017 dch  output  CHW  channel of dout.
REQ-018 ov  output  1  one-cycle strobe, dout/dch/ovf valid.
REQ-019 ovf  output  1  overflow flag for the current dout.
REQ-020 ovf_any  output  1  sticky OR of all ovf since reset.

Function
REQ-021 SHALL run a fixed 4-stage pipeline: S1 register inputs; S2 full PW-bit signed product; S3 accumulate into per-channel ACCW-bit register acc[ch]; S4 round, saturate, register outputs.
REQ-022 SHALL assert ov exactly 4 cycles after a vld cycle with last=1; ov SHALL be low otherwise.
REQ-023 SHALL in S3 set acc[ch]=product when first=1, else acc[ch]+product; the term is in full ACCW precision with wrap-around.
REQ-024 SHALL ignore cycles with vld=0 (bubbles) and any vld term with ch>=NCH; the pipeline never stalls.
REQ-025 SHALL treat first=last=1 as a single-term sum.
REQ-026 SHALL discard the previous partial sum for the channel when first=1 arrives before that channel's last.
REQ-027 SHALL keep channel accumulators independent; any interleaving of channels, including the same channel on back-to-back cycles, gives exact results.
REQ-028 SHALL define LSB=OUT_MSB-OW+1; the rounding constant is 0 for RND=0, and for RND=1 is 2^(LSB-1) for non-negative sums and 2^(LSB-1)-1 for negative sums, added at ACCW+1 bits.
REQ-029 SHALL flag overflow when the rounded value's bits [ACCW:OUT_MSB] are not all equal.
REQ-030 SHALL, on overflow, output +(2^(OW-1)-1) for a non-negative sum and -(2^(OW-1)-1) for a negative sum (symmetric), else output bits [OUT_MSB:LSB].
REQ-031 SHALL register dout, dch and ovf with ov; they hold their values between ov strobes.
REQ-032 SHALL set ovf_any when ov=1 and ovf=1; only reset clears it.

Reset
REQ-033 SHALL, while rst=0, asynchronously clear all pipeline valids, acc[0..NCH-1], dout=0, dch=0, ov=0, ovf=0 and ovf_any=0.
REQ-034 SHALL discard in-flight terms when reset asserts mid-sum; after release, no ov appears until a new last term, and a sum without first starts from 0.

Verification (defaults; LSB=22)
REQ-035 ch=0, din=1, cin=2^22, first=last=1 -> 4 cycles later ov=1, dout=1, dch=0, ovf=0.
REQ-036 din=3, cin=2^21, single term -> dout=2; din=-3 -> dout=-2 (0xFFFFE); with RND=0, din=-3 -> dout=-2 and din=3 -> dout=1.
REQ-037 ch=1, two terms din=131071, cin=16777215 -> ov after the second term, dout=0x7FFFF, ovf=1, ovf_any=1; then single term din=-131071, cin=16777215 twice on ch=1 -> dout=0x80001, ovf=1.
REQ-038 alternate ch0/ch1 each cycle for 8 terms (ch0: din=1, cin=2^22; ch1: din=2, cin=2^22) -> ch0 dout=4, ch1 dout=8, ov strobes in input order with correct dch.
REQ-039 ch=2 first term, then ch=2 first again with no intervening last, then last -> dout reflects only the last two terms; a vld term with ch>=NCH (NCH=3 build) produces no effect.
REQ-040 assert rst for 1 cycle after the 3rd of 5 terms on ch=0 -> no ov; the next first/last single term din=1, cin=2^22 -> dout=1, ovf_any=0.
